// File: rtl/axi_mem_bridge.sv
// axi_mem_bridge: turns one MMU memory request into a single AXI4-Lite
// master transaction and returns a one-cycle completion pulse.
// Ports:
//   clk, rstn                    clock, synchronous active-low reset
//   request_enable, req_*        request pulse, mode (0 rd / 1 wr), addr, wdata, wstrb
//   response_enable, resp_data,  completion pulse, read data (held), error flag
//   resp_error, busy             busy spans accept cycle through response cycle
//   axi_ar*/r*/aw*/w*/b*         AXI4-Lite master channels
module axi_mem_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [2:0]  AXPROT     = 3'b000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  request_enable,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  response_enable,
    output logic [31:0]           resp_data,
    output logic                  resp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [2:0]            axi_arprot,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [31:0]           axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [ADDR_WIDTH-1:0] axi_awaddr,
    output logic [2:0]            axi_awprot,
    output logic                  axi_awvalid,
    input  logic                  axi_awready,
    output logic [31:0]           axi_wdata,
    output logic [3:0]            axi_wstrb,
    output logic                  axi_wvalid,
    input  logic                  axi_wready,
    input  logic [1:0]            axi_bresp,
    input  logic                  axi_bvalid,
    output logic                  axi_bready
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state,  w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,   w_addr_nxt;
    logic [DATA_W-1:0]     r_wdata,  w_wdata_nxt;
    logic [STRB_W-1:0]     r_wstrb,  w_wstrb_nxt;
    logic                  r_arvalid, w_arvalid_nxt;
    logic                  r_rready,  w_rready_nxt;
    logic                  r_awvalid, w_awvalid_nxt;
    logic                  r_wvalid,  w_wvalid_nxt;
    logic                  r_bready,  w_bready_nxt;
    logic [DATA_W-1:0]     r_resp_data,  w_resp_data_nxt;
    logic                  r_resp_error, w_resp_error_nxt;
    logic                  r_resp_en,    w_resp_en_nxt;
    logic                  r_busy,       w_busy_nxt;

    // A write channel is finished once its VALID is low or handshakes this cycle
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || axi_awready;
    assign w_w_done  = !r_wvalid  || axi_wready;

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_wdata_nxt      = r_wdata;
        w_wstrb_nxt      = r_wstrb;
        w_arvalid_nxt    = r_arvalid;
        w_rready_nxt     = r_rready;
        w_awvalid_nxt    = r_awvalid;
        w_wvalid_nxt     = r_wvalid;
        w_bready_nxt     = r_bready;
        w_resp_data_nxt  = r_resp_data;
        w_resp_error_nxt = r_resp_error;

        case (r_state)
            S_IDLE: begin
                if (request_enable) begin
                    w_addr_nxt  = req_addr;
                    w_wdata_nxt = req_wdata;
                    w_wstrb_nxt = req_wstrb;
                    if (req_mode) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_state_nxt   = S_WRITE;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_state_nxt   = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (r_arvalid && axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_rready && axi_rvalid) begin
                    w_rready_nxt     = 1'b0;
                    w_resp_data_nxt  = axi_rdata;
                    w_resp_error_nxt = (axi_rresp != 2'b00);
                    w_state_nxt      = S_DONE;
                end
            end
            S_WRITE: begin
                // AW and W retire independently; B is opened once both are done
                w_awvalid_nxt = r_awvalid && !axi_awready;
                w_wvalid_nxt  = r_wvalid  && !axi_wready;
                if (w_aw_done && w_w_done) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (r_bready && axi_bvalid) begin
                    w_bready_nxt     = 1'b0;
                    w_resp_data_nxt  = '0;
                    w_resp_error_nxt = (axi_bresp != 2'b00);
                    w_state_nxt      = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_resp_en_nxt = (w_state_nxt == S_DONE);
        w_busy_nxt    = (w_state_nxt != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
            r_resp_en    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_wstrb      <= w_wstrb_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_resp_data  <= w_resp_data_nxt;
            r_resp_error <= w_resp_error_nxt;
            r_resp_en    <= w_resp_en_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign response_enable = r_resp_en;
    assign resp_data       = r_resp_data;
    assign resp_error      = r_resp_error;
    assign busy            = r_busy;
    assign axi_araddr      = r_addr;
    assign axi_awaddr      = r_addr;
    assign axi_arprot      = AXPROT;
    assign axi_awprot      = AXPROT;
    assign axi_arvalid     = r_arvalid;
    assign axi_rready      = r_rready;
    assign axi_awvalid     = r_awvalid;
    assign axi_wdata       = r_wdata;
    assign axi_wstrb       = r_wstrb;
    assign axi_wvalid      = r_wvalid;
    assign axi_bready      = r_bready;

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Bench for axi_mem_bridge: directed and randomized requests against an
// AXI4-Lite slave with programmable stalls and an abstract memory model.
module tb_axi_mem_bridge;

    logic        clk;
    logic        rstn;
    logic        request_enable;
    logic        req_mode;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        response_enable;
    logic [31:0] resp_data;
    logic        resp_error;
    logic        busy;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    axi_mem_bridge dut (
        .clk(clk), .rstn(rstn),
        .request_enable(request_enable), .req_mode(req_mode), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .response_enable(response_enable), .resp_data(resp_data),
        .resp_error(resp_error), .busy(busy),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    // Slave configuration: stall cycles per channel and response codes
    int         ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
    logic [1:0] rresp_cfg = 2'b00, bresp_cfg = 2'b00;

    // Observation counters maintained by the slave process
    int n_resp = 0, n_ar_hs = 0, proto_err = 0;

    logic [31:0] smem [bit [29:0]];
    logic [31:0] mmem [bit [29:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return smem.exists(a[31:2]) ? smem[a[31:2]] : dflt(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return mmem.exists(a[31:2]) ? mmem[a[31:2]] : dflt(a);
    endfunction

    // AXI4-Lite slave: acts on the negative edge, looking back at the previous cycle
    initial begin : slave
        logic        p_arv, p_rr, p_awv, p_wv, p_br;
        logic [31:0] p_araddr, p_awaddr, p_wdata;
        logic [3:0]  p_wstrb;
        int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        logic        rd_pend, b_pend, have_aw, have_w;
        logic [31:0] rd_addr, wr_addr, wr_data;
        logic [3:0]  wr_strb;
        p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0; p_wstrb = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; b_pend = 0; have_aw = 0; have_w = 0;
        rd_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
        forever begin
            @(negedge clk);
            if (response_enable) n_resp++;
            if (!rstn) begin
                p_arv = 0; p_rr = 0; p_awv = 0; p_wv = 0; p_br = 0;
                ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                rd_pend = 0; b_pend = 0; have_aw = 0; have_w = 0;
                axi_arready = 0; axi_rvalid = 0; axi_awready = 0;
                axi_wready = 0; axi_bvalid = 0;
            end else begin
                if (p_rr && axi_rvalid) rd_pend = 0;
                else if (rd_pend) r_cnt++;
                if (p_br && axi_bvalid) b_pend = 0;
                else if (b_pend) b_cnt++;
                if (p_arv) begin
                    if (axi_arready) begin
                        rd_addr = p_araddr; rd_pend = 1; r_cnt = 0; ar_cnt = 0; n_ar_hs++;
                    end else begin
                        ar_cnt++;
                        if (!axi_arvalid || axi_araddr !== p_araddr) proto_err++;
                    end
                end
                if (p_awv) begin
                    if (axi_awready) begin
                        wr_addr = p_awaddr; have_aw = 1; aw_cnt = 0;
                    end else begin
                        aw_cnt++;
                        if (!axi_awvalid || axi_awaddr !== p_awaddr) proto_err++;
                    end
                end
                if (p_wv) begin
                    if (axi_wready) begin
                        wr_data = p_wdata; wr_strb = p_wstrb; have_w = 1; w_cnt = 0;
                    end else begin
                        w_cnt++;
                        if (!axi_wvalid || axi_wdata !== p_wdata || axi_wstrb !== p_wstrb)
                            proto_err++;
                    end
                end
                if (have_aw && have_w) begin
                    smem[wr_addr[31:2]] = merge(slave_rd(wr_addr), wr_data, wr_strb);
                    have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
                end
                axi_arready = axi_arvalid && (ar_cnt >= ar_dly);
                axi_rvalid  = rd_pend && (r_cnt >= r_dly);
                axi_rdata   = rd_pend ? slave_rd(rd_addr) : 32'h0;
                axi_rresp   = rresp_cfg;
                axi_awready = axi_awvalid && (aw_cnt >= aw_dly);
                axi_wready  = axi_wvalid && (w_cnt >= w_dly);
                axi_bvalid  = b_pend && (b_cnt >= b_dly);
                axi_bresp   = bresp_cfg;
                p_arv = axi_arvalid; p_rr = axi_rready; p_awv = axi_awvalid;
                p_wv = axi_wvalid; p_br = axi_bready;
                p_araddr = axi_araddr; p_awaddr = axi_awaddr;
                p_wdata = axi_wdata; p_wstrb = axi_wstrb;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Pulse a request in the current cycle; returns in the following cycle
    task automatic start(input logic mode, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        request_enable = 1'b1;
        req_mode  = mode;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        t0 = cyc;
        if (mode) mmem[a[31:2]] = merge(model_rd(a), d, s);
        tick();
        request_enable = 1'b0;
    endtask

    // Wait (bounded) for the response pulse, check it, then check the idle cycle after
    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_data,
                             input logic exp_err);
        while (response_enable !== 1'b1 && (cyc - t0) < 40) tick();
        chk1({tag, "_resp_en"}, response_enable, 1'b1);
        chk({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        chk({tag, "_data"}, resp_data, exp_data);
        chk1({tag, "_err"}, resp_error, exp_err);
        chk1({tag, "_busy_at_resp"}, busy, 1'b1);
        tick();
        chk1({tag, "_pulse_one_cycle"}, response_enable, 1'b0);
        chk1({tag, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_arvalid"}, axi_arvalid, 1'b0);
        chk1({tag, "_rready"}, axi_rready, 1'b0);
        chk1({tag, "_awvalid"}, axi_awvalid, 1'b0);
        chk1({tag, "_wvalid"}, axi_wvalid, 1'b0);
        chk1({tag, "_bready"}, axi_bready, 1'b0);
        chk1({tag, "_resp_en"}, response_enable, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin : main
        int          nr0;
        int          ar0;
        logic        m;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          lat;
        logic        e;
        rstn = 1'b0;
        request_enable = 1'b0;
        req_mode = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        smem[30'h2000_0004] = 32'hDEAD_BEEF;
        mmem[30'h2000_0004] = 32'hDEAD_BEEF;
        tick();
        tick();
        chk_quiet("reset");
        chk("reset_resp_data", resp_data, 32'h0);
        chk1("reset_resp_error", resp_error, 1'b0);
        chk("reset_araddr", axi_araddr, 32'h0);
        rstn = 1'b1;
        tick();

        // Read with every slave signal ready
        start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        chk1("rd_basic_arvalid_c1", axi_arvalid, 1'b1);
        chk("rd_basic_araddr_c1", axi_araddr, 32'h8000_0010);
        chk("rd_basic_arprot", 32'(axi_arprot), 32'h0);
        chk1("rd_basic_busy_c1", busy, 1'b1);
        chk1("rd_basic_awvalid_c1", axi_awvalid, 1'b0);
        wait_resp("rd_basic", 3, 32'hDEAD_BEEF, 1'b0);

        // Read with AR stalled 3 and R stalled 2
        ar_dly = 3; r_dly = 2;
        start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        tick(); tick();
        chk("rd_stall_araddr_held", axi_araddr, 32'h8000_0010);
        chk1("rd_stall_arvalid_held", axi_arvalid, 1'b1);
        wait_resp("rd_stall", 8, 32'hDEAD_BEEF, 1'b0);
        ar_dly = 0; r_dly = 0;

        // Write where W completes two cycles before AW
        aw_dly = 3; w_dly = 1;
        start(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b0101);
        chk1("wr_order_awvalid_c1", axi_awvalid, 1'b1);
        chk1("wr_order_wvalid_c1", axi_wvalid, 1'b1);
        tick(); tick();
        chk1("wr_order_wvalid_dropped", axi_wvalid, 1'b0);
        chk1("wr_order_awvalid_held", axi_awvalid, 1'b1);
        chk1("wr_order_bready_early_c3", axi_bready, 1'b0);
        tick();
        chk1("wr_order_bready_early_c4", axi_bready, 1'b0);
        tick();
        chk1("wr_order_bready_c5", axi_bready, 1'b1);
        chk1("wr_order_awvalid_c5", axi_awvalid, 1'b0);
        wait_resp("wr_order", 6, 32'h0, 1'b0);
        aw_dly = 0; w_dly = 0;
        start(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        wait_resp("wr_readback", 3, model_rd(32'h0000_1000), 1'b0);

        // Error responses
        bresp_cfg = 2'b10;
        start(1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'hF);
        wait_resp("wr_slverr", 3, 32'h0, 1'b1);
        bresp_cfg = 2'b00; rresp_cfg = 2'b11;
        start(1'b0, 32'h0000_1004, 32'h0, 4'h0);
        wait_resp("rd_decerr", 3, model_rd(32'h0000_1004), 1'b1);
        rresp_cfg = 2'b00;

        // A request pulsed while in RDATA must be ignored
        r_dly = 3;
        nr0 = n_resp; ar0 = n_ar_hs;
        start(1'b0, 32'h8000_0010, 32'h0, 4'h0);
        tick();
        request_enable = 1'b1; req_mode = 1'b0; req_addr = 32'h0000_2000;
        tick();
        request_enable = 1'b0;
        wait_resp("rd_ignore", 6, 32'hDEAD_BEEF, 1'b0);
        tick(); tick(); tick();
        chk("rd_ignore_ar_handshakes", 32'(n_ar_hs - ar0), 32'd1);
        chk("rd_ignore_responses", 32'(n_resp - nr0), 32'd1);
        r_dly = 0;

        // Reset while in RADDR abandons the transaction
        ar_dly = 5;
        nr0 = n_resp;
        start(1'b0, 32'h0000_1008, 32'h0, 4'h0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk_quiet("mid_reset");
        tick(); tick(); tick();
        chk("mid_reset_no_resp", 32'(n_resp - nr0), 32'd0);
        ar_dly = 0;
        start(1'b0, 32'h0000_1008, 32'h0, 4'h0);
        wait_resp("post_reset_rd", 3, model_rd(32'h0000_1008), 1'b0);

        // Randomized back-to-back traffic with random stalls and errors
        for (int i = 0; i < 30; i++) begin
            m = 1'($urandom_range(0, 1));
            a = 32'h0000_1000 + 32'(4 * $urandom_range(0, 7));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly = $urandom_range(0, 3);
            e = ($urandom_range(0, 5) == 0);
            rresp_cfg = e ? 2'b10 : 2'b00;
            bresp_cfg = e ? 2'b11 : 2'b00;
            if (m) lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            else   lat = 3 + ar_dly + r_dly;
            nr0 = n_resp;
            start(m, a, d, s);
            wait_resp($sformatf("rand%0d_%s", i, m ? "wr" : "rd"), lat,
                      m ? 32'h0 : model_rd(a), e);
            chk($sformatf("rand%0d_one_pulse", i), 32'(n_resp - nr0), 32'd1);
        end
        rresp_cfg = 2'b00; bresp_cfg = 2'b00;

        chk("axi_stability_violations", 32'(proto_err), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_bridge.md
# axi_mem_bridge

Downstream neighbour of the MMU: converts its single-outstanding physical memory request (`request_enable`/`req_*`) into one AXI4-Lite master transaction and returns completion as a one-cycle `response_enable` pulse with read data. Sits between the MMU and the SoC interconnect. Exactly one transaction is in flight at any time. It has no caching, reordering or bursts.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: AXI address width. `req_addr` is passed through unchanged.
- `AXPROT`, 3'b000: constant value driven on `arprot`/`awprot`.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  synchronous active-low reset.
- `request_enable`  in  1  one-cycle request pulse from the MMU.
- `req_mode`  in  1  0 = read, 1 = write.
- `req_addr`  in  32  physical byte address.
- `req_wdata`  in  32  write data.
- `req_wstrb`  in  4  byte strobes (writes only).
- `response_enable`  out  1  one-cycle completion pulse.
- `resp_data`  out  32  read data; valid while `response_enable`=1, held until the next response.
- `resp_error`  out  1  valid with `response_enable`: 1 if RRESP/BRESP is not OKAY (2'b00).
- `busy`  out  1  high from the accept cycle through the `response_enable` cycle.
- AR channel: `axi_araddr` out 32, `axi_arprot` out 3, `axi_arvalid` out 1, `axi_arready` in 1.
- R channel: `axi_rdata` in 32, `axi_rresp` in 2, `axi_rvalid` in 1, `axi_rready` out 1.
- AW channel: `axi_awaddr` out 32, `axi_awprot` out 3, `axi_awvalid` out 1, `axi_awready` in 1.
- W channel: `axi_wdata` out 32, `axi_wstrb` out 4, `axi_wvalid` out 1, `axi_wready` in 1.
- B channel: `axi_bresp` in 2, `axi_bvalid` in 1, `axi_bready` out 1.

## Operation
- States: IDLE, RADDR, RDATA, WRITE, WRESP, DONE.
- IDLE:
  - `request_enable`=1 latches addr/wdata/wstrb into channel registers.
  - `req_mode`=0 goes to RADDR (`arvalid`←1).
  - `req_mode`=1 goes to WRITE (`awvalid`←1, `wvalid`←1 in the same cycle).
- RADDR:
  - `arvalid` held with stable `araddr` until `arvalid&arready`.
  - On that handshake: `arvalid`←0, `rready`←1, go to RDATA.
- RDATA: on `rvalid&rready`:
  - `rready`←0.
  - `resp_data`←`rdata`, `resp_error`←(`rresp`≠0).
  - Go to DONE.
- WRITE:
  - AW and W are independent. `awvalid` drops on its own handshake; `wvalid` drops on its own handshake.
  - The two handshakes may occur in the same cycle or in either order.
  - When both are complete (including the cycle the second completes): `bready`←1, go to WRESP.
- WRESP: on `bvalid&bready`:
  - `bready`←0.
  - `resp_data`←0, `resp_error`←(`bresp`≠0).
  - Go to DONE.
- DONE: `response_enable`=1 for exactly this cycle; next state IDLE.
- `request_enable` outside IDLE is ignored; it is neither queued nor able to corrupt state. Upstream must wait for `busy`=0.
- All valid/ready outputs are registered. VALIDs never depend combinationally on READYs (AXI rule). Address, data and strobes are stable while their VALID is high.
- Reset (`rstn`=0 at an edge): state IDLE; all VALID/READY outputs 0; `response_enable`, `resp_error`, `busy` 0; `resp_data` 0; address/data registers 0.
  - A transaction in flight is abandoned with no response pulse.
  - Integration guarantees the interconnect is reset together with this block.

## Timing
- Request pulse at edge N: VALID(s) high from cycle N+1; `busy` high from N+1.
- Read with `arready`=1 and `rvalid`=1 permanently: `arvalid` high in N+1; `rready` high in N+2; capture at edge N+2→N+3; `response_enable` in N+3. Minimum latency is 3 cycles.
- Write with all readies=1 and `bvalid`=1: AW/W handshake in N+1; `bready` in N+2; `response_enable` in N+3.
- Each stall cycle on any slave ready/valid adds exactly one cycle.
- Back-to-back: a new request is accepted in the cycle after DONE (IDLE). Peak throughput is one transaction per 4 cycles.

## Test plan
- Read, all slave signals ready: request addr 0x8000_0010 at cycle 0. Required: `arvalid` in cycle 1 with `araddr`=0x8000_0010; `rdata`=0xDEADBEEF; `response_enable` in cycle 3, `resp_data`=0xDEADBEEF, `resp_error`=0.
- Read with `arready` delayed 3 cycles and `rvalid` delayed 2 cycles: `araddr` stays stable throughout; response arrives at cycle 3+3+2=8 with correct data.
- Write with `wready` 2 cycles before `awready`, wdata=0x12345678, wstrb=4'b0101: `wvalid` drops first and `awvalid` stays high; `bready` asserts only after both handshakes; single `response_enable`, `resp_error`=0.
- Error responses: `bresp`=2'b10 on a write gives `resp_error`=1 and `resp_data`=0. `rresp`=2'b11 on a read gives `resp_error`=1.
- `request_enable` pulsed in RDATA with a different address: no second AR handshake; exactly one `response_enable` carrying the first request's data.
- `rstn`=0 for one cycle while in RADDR: all VALID/READY outputs are 0 the next cycle, no `response_enable`, `busy`=0; a fresh request afterwards completes normally.
